// File: rtl/ram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : ram_cmd_arbiter
// Description : Two-requester round-robin arbiter and command sequencer for
//               the 256x8 command-driven RAM. Each transaction is expanded
//               into 10-bit RAM command words; read data (or a timeout error)
//               is returned on the winning requester's response port.
// Option      : `define RAM_ARB_ADDR_CACHE_EN to skip the address phase when
//               the granted address equals the last address issued.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_cmd_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic                 req0_wr,
  input  logic [ADDR_SIZE-1:0] req0_addr,
  input  logic [7:0]           req0_wdata,
  output logic                 rsp0_valid,
  output logic [7:0]           rsp0_rdata,
  output logic                 rsp0_err,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic                 req1_wr,
  input  logic [ADDR_SIZE-1:0] req1_addr,
  input  logic [7:0]           req1_wdata,
  output logic                 rsp1_valid,
  output logic [7:0]           rsp1_rdata,
  output logic                 rsp1_err,
  output logic [9:0]           ram_din,
  output logic                 ram_rx_valid,
  input  logic [7:0]           ram_dout,
  input  logic                 ram_tx_valid
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  C_TO_MAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_RWAIT = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   last_grant_q, last_grant_d;
  logic                   id_q, id_d;
  logic                   wr_q, wr_d;
  logic [ADDR_SIZE-1:0]   addr_q, addr_d;
  logic [7:0]             wdata_q, wdata_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [7:0]             rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                   err0_q, err0_d, err1_q, err1_d;
`ifdef RAM_ARB_ADDR_CACHE_EN
  logic [ADDR_SIZE-1:0]   cache_addr_q, cache_addr_d;
  logic                   cache_vld_q, cache_vld_d;
`endif

  logic                   gnt_any;
  logic                   gnt_id;
  logic                   gnt_wr;
  logic [ADDR_SIZE-1:0]   gnt_addr;
  logic [7:0]             gnt_wdata;
  logic [7:0]             addr_ext;
  logic [CW-1:0]          cnt_inc;

  assign addr_ext   = 8'(addr_q);
  assign cnt_inc    = cnt_q + 1'b1;
  assign rsp0_rdata = rdata0_q;
  assign rsp0_err   = err0_q;
  assign rsp1_rdata = rdata1_q;
  assign rsp1_err   = err1_q;

  // Round-robin pick: a tie goes to the requester that did not win last time.
  always_comb begin
    gnt_any = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_grant_q;
    end else begin
      gnt_id = req1_valid;
    end
    gnt_wr    = gnt_id ? req1_wr    : req0_wr;
    gnt_addr  = gnt_id ? req1_addr  : req0_addr;
    gnt_wdata = gnt_id ? req1_wdata : req0_wdata;
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      rdata0_q     <= '0;
      err0_q       <= 1'b0;
      rdata1_q     <= '0;
      err1_q       <= 1'b0;
`ifdef RAM_ARB_ADDR_CACHE_EN
      cache_addr_q <= '0;
      cache_vld_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      rdata0_q     <= rdata0_d;
      err0_q       <= err0_d;
      rdata1_q     <= rdata1_d;
      err1_q       <= err1_d;
`ifdef RAM_ARB_ADDR_CACHE_EN
      cache_addr_q <= cache_addr_d;
      cache_vld_q  <= cache_vld_d;
`endif
    end
  end

  // Next-state logic and Moore/handshake outputs for the sequencer.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rdata0_d     = rdata0_q;
    err0_d       = err0_q;
    rdata1_d     = rdata1_q;
    err1_d       = err1_q;
`ifdef RAM_ARB_ADDR_CACHE_EN
    cache_addr_d = cache_addr_q;
    cache_vld_d  = cache_vld_q;
`endif
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    rsp0_valid   = 1'b0;
    rsp1_valid   = 1'b0;
    ram_rx_valid = 1'b0;
    ram_din      = 10'h000;

    case (state_q)
      S_IDLE: begin
        if (gnt_any) begin
          req0_ready   = ~gnt_id;
          req1_ready   = gnt_id;
          id_d         = gnt_id;
          wr_d         = gnt_wr;
          addr_d       = gnt_addr;
          wdata_d      = gnt_wdata;
          last_grant_d = gnt_id;
          state_d      = S_ADDR;
`ifdef RAM_ARB_ADDR_CACHE_EN
          // RAM still holds this address from the previous command pair.
          if (cache_vld_q && (cache_addr_q == gnt_addr)) begin
            state_d = S_DATA;
          end
`endif
        end
      end

      S_ADDR: begin
        ram_rx_valid = 1'b1;
        ram_din      = {(wr_q ? 2'b00 : 2'b10), addr_ext};
`ifdef RAM_ARB_ADDR_CACHE_EN
        cache_addr_d = addr_q;
        cache_vld_d  = 1'b1;
`endif
        state_d      = S_DATA;
      end

      S_DATA: begin
        ram_rx_valid = 1'b1;
        ram_din      = wr_q ? {2'b01, wdata_q} : {2'b11, 8'h00};
        if (wr_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = '0;
          state_d = S_RWAIT;
        end
      end

      S_RWAIT: begin
        // Read command held on the bus so the RAM keeps presenting data.
        ram_din = {2'b11, 8'h00};
        if (ram_tx_valid) begin
          if (id_q) begin
            rdata1_d = ram_dout;
            err1_d   = 1'b0;
          end else begin
            rdata0_d = ram_dout;
            err0_d   = 1'b0;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == C_TO_MAX) begin
            if (id_q) begin
              rdata1_d = 8'hFF;
              err1_d   = 1'b1;
            end else begin
              rdata0_d = 8'hFF;
              err0_d   = 1'b1;
            end
            state_d = S_RESP;
          end
        end
      end

      S_RESP: begin
        rsp0_valid = ~id_q;
        rsp1_valid = id_q;
        state_d    = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_cmd_arbiter
// Description : Directed self-checking bench for ram_cmd_arbiter with a small
//               behavioural stand-in for the command-driven RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_cmd_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0_valid = 1'b0, req0_wr = 1'b0;
  logic [7:0] req0_addr = 8'h00, req0_wdata = 8'h00;
  logic       req1_valid = 1'b0, req1_wr = 1'b0;
  logic [7:0] req1_addr = 8'h00, req1_wdata = 8'h00;
  logic       req0_ready, req1_ready;
  logic       rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
  logic [7:0] rsp0_rdata, rsp1_rdata;
  logic [9:0] ram_din;
  logic       ram_rx_valid;
  logic [7:0] ram_dout = 8'h00;
  logic       ram_tx_valid = 1'b0;
  logic       stub_mute = 1'b0;
  logic [7:0] ram_a = 8'h00;
  logic [7:0] mem [256];

  int checks = 0;
  int errors = 0;

  int         lat;
  logic [7:0] rd;
  logic       er;
  bit         saw;

  ram_cmd_arbiter #(.ADDR_SIZE(8), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_wr(req0_wr),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_wr(req1_wr),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  always #5 clk = ~clk;

  // RAM stand-in: latch address, write data, answer a read one cycle later.
  always @(posedge clk) begin
    ram_tx_valid <= 1'b0;
    if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00, 2'b10: ram_a <= ram_din[7:0];
        2'b01:        mem[ram_a] <= ram_din[7:0];
        default: begin
          if (!stub_mute) begin
            ram_tx_valid <= 1'b1;
            ram_dout     <= mem[ram_a];
          end
        end
      endcase
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requester-0 read: returns cycles from ready to rsp0_valid, or 0 if no response arrives.
  task automatic read0(input logic [7:0] a, output int l, output logic [7:0] d,
                       output logic e, output bit s);
    l = 0; d = 8'h00; e = 1'b0; s = 1'b0;
    req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = a;
    #1;
    chk("rd_ready0", {31'd0, req0_ready}, 32'd1);
    for (int i = 1; i <= 12; i++) begin
      tick();
      req0_valid = 1'b0;
      if (ram_rx_valid && ram_din == {2'b10, a}) s = 1'b1;
      if (rsp0_valid) begin
        l = i; d = rsp0_rdata; e = rsp0_err;
        break;
      end
    end
    tick();
  endtask

  initial begin
    // Reset state
    tick(); tick();
    chk("rst_ctrl", {15'd0, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                     rsp0_err, rsp1_err, ram_rx_valid, ram_din}, 32'd0);
    chk("rst_rdata", {16'd0, rsp0_rdata, rsp1_rdata}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Requester 0 write 0x12 <- 0xA5
    req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 8'h12; req0_wdata = 8'hA5;
    #1;
    chk("t1_ready", {30'd0, req0_ready, req1_ready}, 32'h2);
    tick();
    req0_valid = 1'b0; req0_wr = 1'b0;
    chk("t1_addr", {1'b1, 10'h012} & 11'h7FF, {ram_rx_valid, ram_din});
    tick();
    chk("t1_data", {ram_rx_valid, ram_din}, {1'b1, 10'h1A5});
    tick();
    chk("t1_idle", {ram_rx_valid, ram_din, rsp0_valid, rsp1_valid}, 32'd0);

    // Requester 1 read 0x12
    req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 8'h12;
    #1;
    chk("t2_ready", {30'd0, req0_ready, req1_ready}, 32'h1);
    tick();
    req1_valid = 1'b0;
`ifndef RAM_ARB_ADDR_CACHE_EN
    chk("t2_addr", {ram_rx_valid, ram_din}, {1'b1, 10'h212});
    tick();
`endif
    chk("t2_data", {ram_rx_valid, ram_din}, {1'b1, 10'h300});
    tick();
    chk("t2_rwait", {ram_rx_valid, ram_din, rsp1_valid}, {1'b0, 10'h300, 1'b0});
    tick();
    chk("t2_rsp1", {rsp1_valid, rsp1_err, rsp1_rdata}, {1'b1, 1'b0, 8'hA5});
    chk("t2_rsp0", {rsp0_valid, rsp0_err, rsp0_rdata}, 32'd0);
    tick();
    chk("t2_hold", {rsp1_valid, rsp1_rdata}, {1'b0, 8'hA5});

    // Round-robin: both writes held from reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 8'h20; req0_wdata = 8'h11;
    req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 8'h40; req1_wdata = 8'h22;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_grant", {30'd0, req0_ready, req1_ready}, (k % 2 == 0) ? 32'h2 : 32'h1);
      tick();
      chk("t3_busy", {30'd0, req0_ready, req1_ready}, 32'd0);
      chk("t3_addr", {22'd0, ram_din}, (k % 2 == 0) ? 32'h020 : 32'h040);
      tick();
      chk("t3_data", {22'd0, ram_din}, (k % 2 == 0) ? 32'h111 : 32'h122);
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // Timeout: RAM never answers
    stub_mute = 1'b1;
    req0_valid = 1'b1; req0_wr = 1'b0; req0_addr = 8'h55;
    #1;
    chk("t4_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    tick();
    chk("t4_data", {ram_rx_valid, ram_din}, {1'b1, 10'h300});
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_wait", {rsp0_valid, ram_rx_valid, ram_din}, {1'b0, 1'b0, 10'h300});
    end
    tick();
    chk("t4_rsp0", {rsp0_valid, rsp0_err, rsp0_rdata}, {1'b1, 1'b1, 8'hFF});
    chk("t4_rsp1", {rsp1_valid, rsp1_err, rsp1_rdata}, 32'd0);
    stub_mute = 1'b0;
    tick();

    // Reset in the DATA phase of a read
    req1_valid = 1'b1; req1_wr = 1'b0; req1_addr = 8'h40;
    #1;
    chk("t5_ready", {30'd0, req0_ready, req1_ready}, 32'h1);
    tick();
    req1_valid = 1'b0;
    tick();
    chk("t5_data", {ram_rx_valid, ram_din}, {1'b1, 10'h300});
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async", {ram_rx_valid, ram_din, rsp0_valid, rsp1_valid, rsp0_rdata}, 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_norsp", {rsp0_valid, rsp1_valid, ram_rx_valid}, 32'd0);
    end
    req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 8'h60; req0_wdata = 8'h33;
    req1_valid = 1'b1; req1_wr = 1'b1; req1_addr = 8'h70; req1_wdata = 8'h44;
    #1;
    chk("t5_first", {30'd0, req0_ready, req1_ready}, 32'h2);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick();

    // Address reuse: write 0x30, read 0x30, read 0x31
    req0_valid = 1'b1; req0_wr = 1'b1; req0_addr = 8'h30; req0_wdata = 8'h5A;
    #1;
    chk("t6_wready", {31'd0, req0_ready}, 32'd1);
    tick();
    req0_valid = 1'b0;
    chk("t6_waddr", {ram_rx_valid, ram_din}, {1'b1, 10'h030});
    tick(); tick();
    read0(8'h30, lat, rd, er, saw);
    chk("t6_rdata", {er, rd}, {1'b0, 8'h5A});
`ifdef RAM_ARB_ADDR_CACHE_EN
    chk("t6_lat_same", lat, 32'd3);
    chk("t6_addr_same", {31'd0, saw}, 32'd0);
`else
    chk("t6_lat_same", lat, 32'd4);
    chk("t6_addr_same", {31'd0, saw}, 32'd1);
`endif
    read0(8'h31, lat, rd, er, saw);
    chk("t6_lat_new", lat, 32'd4);
    chk("t6_addr_new", {31'd0, saw}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
